// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: measures high-pulse widths on the synchronised
// input, rebuilds 24-bit pixel words and reports frame ends and decode errors.
module ws2812_rx #(
    parameter int BITS_PER_PIXEL = 24,
    parameter int PX_COUNT_WIDTH = 6,
    parameter int MAX_PIXELS     = 32,
    parameter int MIN_HIGH       = 10,
    parameter int BIT_THRESH     = 60,
    parameter int MAX_HIGH       = 120,
    parameter int LATCH_CYCLES   = 5000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din,
    output logic [BITS_PER_PIXEL-1:0] pixel,
    output logic                      pixel_valid,
    output logic [PX_COUNT_WIDTH-1:0] pixel_idx,
    output logic                      frame_done,
    output logic [PX_COUNT_WIDTH-1:0] frame_px,
    output logic                      err,
    output logic [1:0]                err_code
);

    localparam int HCNT_W = $clog2(MAX_HIGH + 2);
    localparam int LCNT_W = $clog2(LATCH_CYCLES + 1);
    localparam int BCNT_W = $clog2(BITS_PER_PIXEL);

    localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);
    localparam logic [HCNT_W-1:0] HCNT_SAT  = HCNT_W'(MAX_HIGH + 1);
    localparam logic [HCNT_W-1:0] HCNT_MIN  = HCNT_W'(MIN_HIGH);
    localparam logic [HCNT_W-1:0] HCNT_BIT1 = HCNT_W'(BIT_THRESH);
    localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(MAX_HIGH);

    localparam logic [LCNT_W-1:0] LCNT_ONE   = LCNT_W'(1);
    localparam logic [LCNT_W-1:0] LCNT_LATCH = LCNT_W'(LATCH_CYCLES);

    localparam logic [BCNT_W-1:0]         BCNT_ONE  = BCNT_W'(1);
    localparam logic [BCNT_W-1:0]         BCNT_LAST = BCNT_W'(BITS_PER_PIXEL - 1);
    localparam logic [PX_COUNT_WIDTH-1:0] PX_ONE    = PX_COUNT_WIDTH'(1);
    localparam logic [PX_COUNT_WIDTH-1:0] PX_MAX    = PX_COUNT_WIDTH'(MAX_PIXELS);

    localparam logic [1:0] ERR_GLITCH  = 2'b01;
    localparam logic [1:0] ERR_STUCK   = 2'b10;
    localparam logic [1:0] ERR_PARTIAL = 2'b11;

    typedef enum logic [1:0] {
        SYNC_WAIT,
        IDLE,
        HIGH,
        LOW
    } state_t;

    function automatic logic [HCNT_W-1:0] hcnt_inc(input logic [HCNT_W-1:0] v);
        return (v >= HCNT_SAT) ? v : v + HCNT_ONE;
    endfunction

    function automatic logic [LCNT_W-1:0] lcnt_inc(input logic [LCNT_W-1:0] v);
        return (v >= LCNT_LATCH) ? v : v + LCNT_ONE;
    endfunction

    logic                      din_s1_q, din_s2_q;
    state_t                    state_q, state_d;
    logic [HCNT_W-1:0]         hcnt_q, hcnt_d;
    logic [LCNT_W-1:0]         lcnt_q, lcnt_d;
    logic [BCNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [PX_COUNT_WIDTH-1:0] px_cnt_q, px_cnt_d;
    logic [BITS_PER_PIXEL-2:0] shift_q, shift_d;
    logic [BITS_PER_PIXEL-1:0] pixel_q, pixel_d;
    logic                      pixel_valid_q, pixel_valid_d;
    logic [PX_COUNT_WIDTH-1:0] pixel_idx_q, pixel_idx_d;
    logic                      frame_done_q, frame_done_d;
    logic [PX_COUNT_WIDTH-1:0] frame_px_q, frame_px_d;
    logic                      err_q, err_d;
    logic [1:0]                err_code_q, err_code_d;

    logic                      din_sync;
    logic                      bit_val;
    logic [BITS_PER_PIXEL-1:0] word_full;

    assign din_sync  = din_s2_q;
    assign bit_val   = (hcnt_q >= HCNT_BIT1);
    // Only the newest BITS_PER_PIXEL-1 bits are stored; the final bit joins on emit.
    assign word_full = {shift_q, bit_val};

    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        lcnt_d        = lcnt_q;
        bit_cnt_d     = bit_cnt_q;
        px_cnt_d      = px_cnt_q;
        shift_d       = shift_q;
        pixel_d       = pixel_q;
        pixel_valid_d = 1'b0;
        pixel_idx_d   = pixel_idx_q;
        frame_done_d  = 1'b0;
        frame_px_d    = frame_px_q;
        err_d         = 1'b0;
        err_code_d    = err_code_q;

        case (state_q)
            SYNC_WAIT: begin
                if (din_sync) begin
                    lcnt_d = '0;
                end else if (lcnt_q == LCNT_LATCH) begin
                    lcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    lcnt_d = lcnt_inc(lcnt_q);
                end
            end

            IDLE: begin
                if (din_sync) begin
                    hcnt_d  = HCNT_ONE;
                    state_d = HIGH;
                end
            end

            HIGH: begin
                if (hcnt_q > HCNT_MAX) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_STUCK;
                    bit_cnt_d  = '0;
                    px_cnt_d   = '0;
                    lcnt_d     = '0;
                    state_d    = SYNC_WAIT;
                end else if (din_sync) begin
                    hcnt_d = hcnt_inc(hcnt_q);
                end else if (hcnt_q < HCNT_MIN) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_GLITCH;
                    bit_cnt_d  = '0;
                    px_cnt_d   = '0;
                    lcnt_d     = '0;
                    state_d    = SYNC_WAIT;
                end else begin
                    shift_d = word_full[BITS_PER_PIXEL-2:0];
                    lcnt_d  = LCNT_ONE;
                    state_d = LOW;
                    if (bit_cnt_q == BCNT_LAST) begin
                        bit_cnt_d = '0;
                        // Past MAX_PIXELS the count saturates and the word is silently dropped.
                        if (px_cnt_q < PX_MAX) begin
                            pixel_valid_d = 1'b1;
                            pixel_d       = word_full;
                            pixel_idx_d   = px_cnt_q;
                            px_cnt_d      = px_cnt_q + PX_ONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCNT_ONE;
                    end
                end
            end

            LOW: begin
                if (din_sync) begin
                    hcnt_d  = HCNT_ONE;
                    state_d = HIGH;
                end else if (lcnt_q == LCNT_LATCH) begin
                    if ((bit_cnt_q != '0) || (px_cnt_q != '0)) begin
                        frame_done_d = 1'b1;
                        frame_px_d   = px_cnt_q;
                        if (bit_cnt_q != '0) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_PARTIAL;
                        end
                    end
                    px_cnt_d  = '0;
                    bit_cnt_d = '0;
                    lcnt_d    = '0;
                    state_d   = IDLE;
                end else begin
                    lcnt_d = lcnt_inc(lcnt_q);
                end
            end

            default: begin
                state_d = SYNC_WAIT;
                lcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_s1_q      <= 1'b0;
            din_s2_q      <= 1'b0;
            state_q       <= SYNC_WAIT;
            hcnt_q        <= '0;
            lcnt_q        <= '0;
            bit_cnt_q     <= '0;
            px_cnt_q      <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            pixel_idx_q   <= '0;
            frame_done_q  <= 1'b0;
            frame_px_q    <= '0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
        end else begin
            din_s1_q      <= din;
            din_s2_q      <= din_s1_q;
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            bit_cnt_q     <= bit_cnt_d;
            px_cnt_q      <= px_cnt_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_idx_q   <= pixel_idx_d;
            frame_done_q  <= frame_done_d;
            frame_px_q    <= frame_px_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    // Shift contents are qualified by bit_cnt, so stale bits after reset are harmless.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign pixel       = pixel_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_idx   = pixel_idx_q;
    assign frame_done  = frame_done_q;
    assign frame_px    = frame_px_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: directed WS2812 waveforms, expected events queued by the
// stimulus and matched by an independent monitor on the DUT strobes.
`timescale 1ns/1ps
module tb_ws2812_rx;

    localparam int CYCLE_LIMIT = 98000;

    localparam logic [1:0] K_PIX = 2'd0;
    localparam logic [1:0] K_FRM = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [23:0] data;
        logic [5:0]  idx;
        logic [1:0]  code;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic [5:0]  pixel_idx;
    logic        frame_done;
    logic [5:0]  frame_px;
    logic        err;
    logic [1:0]  err_code;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    always #5 clk = ~clk;

    ws2812_rx dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .pixel      (pixel),
        .pixel_valid(pixel_valid),
        .pixel_idx  (pixel_idx),
        .frame_done (frame_done),
        .frame_px   (frame_px),
        .err        (err),
        .err_code   (err_code)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_pix(input logic [23:0] d, input logic [5:0] i);
        ev_t e;
        e.kind = K_PIX; e.data = d; e.idx = i; e.code = 2'b00;
        exp_q.push_back(e);
    endtask

    task automatic exp_frm(input logic [5:0] px, input logic [1:0] code);
        ev_t e;
        e.kind = K_FRM; e.data = {18'h0, px}; e.idx = 6'h0; e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic exp_err(input logic [1:0] code);
        ev_t e;
        e.kind = K_ERR; e.data = 24'h0; e.idx = 6'h0; e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    // Nominal datasheet timing at 100 MHz.
    task automatic send_px_nominal(input logic [23:0] v);
        for (int i = 23; i >= 0; i--) begin
            if (v[i]) pulse(80, 45);
            else      pulse(40, 85);
        end
    endtask

    // Compressed timing (still inside the decode windows) to keep the run short.
    task automatic send_bits_fast(input logic [23:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (v[i]) pulse(65, 5);
            else      pulse(15, 5);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {pixel, pixel_valid, pixel_idx, frame_done, frame_px, err, err_code}, 64'h0);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (cyc > CYCLE_LIMIT) begin
            check("cycle_budget", cyc, CYCLE_LIMIT);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
        if (!rst) begin
            if (pixel_valid) begin
                if (exp_q.size() != 0 && exp_q[0].kind == K_PIX) begin
                    mon_e = exp_q.pop_front();
                    check("pixel_data", pixel, mon_e.data);
                    check("pixel_idx", pixel_idx, mon_e.idx);
                end else begin
                    check("pixel_valid_unexpected", pixel_valid, 0);
                end
            end
            if (frame_done) begin
                if (exp_q.size() != 0 && exp_q[0].kind == K_FRM) begin
                    mon_e = exp_q.pop_front();
                    check("frame_px", frame_px, mon_e.data[5:0]);
                    check("frame_err", err, (mon_e.code != 2'b00));
                    if (mon_e.code != 2'b00) check("frame_err_code", err_code, mon_e.code);
                end else begin
                    check("frame_done_unexpected", frame_done, 0);
                end
            end else if (err) begin
                if (exp_q.size() != 0 && exp_q[0].kind == K_ERR) begin
                    mon_e = exp_q.pop_front();
                    check("err_code", err_code, mon_e.code);
                end else begin
                    check("err_unexpected", err, 0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b0;

        // Single pixel at nominal timing, then a long latch gap.
        hold(1'b0, 5100);
        exp_pix(24'hFF0080, 6'd0);
        send_px_nominal(24'hFF0080);
        exp_frm(6'd1, 2'b00);
        hold(1'b0, 6000);
        check("err_code_after_clean_frame", err_code, 2'b00);

        // 34 pixels: only the first 32 are emitted, count saturates at 32.
        for (int n = 1; n <= 34; n++) begin
            if (n <= 32) exp_pix(24'(n), 6'(n - 1));
            send_bits_fast(24'(n), 24);
        end
        exp_frm(6'd32, 2'b00);
        hold(1'b0, 5010);

        // Width boundaries: 59 -> 0, 60 -> 1, 10 -> accepted 0, then a 9-cycle glitch.
        exp_pix(24'hAAAAAA, 6'd0);
        send_bits_fast(24'h155555, 21);
        pulse(59, 5);
        pulse(60, 5);
        pulse(10, 5);
        exp_err(2'b01);
        pulse(9, 5);
        send_bits_fast(24'h000000, 24);
        hold(1'b0, 5010);
        check("err_code_hold_glitch", err_code, 2'b01);
        exp_pix(24'h123456, 6'd0);
        send_bits_fast(24'h123456, 24);
        exp_frm(6'd1, 2'b00);
        hold(1'b0, 5010);
        check("err_code_sticky_over_frame", err_code, 2'b01);

        // Partial pixel at the latch gap.
        exp_frm(6'd0, 2'b11);
        send_bits_fast(24'h000ABC, 12);
        hold(1'b0, 5010);
        check("err_code_partial", err_code, 2'b11);
        exp_pix(24'h5A5A5A, 6'd0);
        send_bits_fast(24'h5A5A5A, 24);

        // Stuck-high line, then recovery through a full latch gap.
        exp_err(2'b10);
        hold(1'b1, 200);
        hold(1'b0, 5010);
        check("err_code_stuck", err_code, 2'b10);
        exp_pix(24'h0F0F0F, 6'd0);
        send_bits_fast(24'h0F0F0F, 24);

        // Reset in the middle of a pixel.
        send_bits_fast(24'h0002A5, 10);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset_mid_frame");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 5010);
        exp_pix(24'hC3C3C3, 6'd0);
        send_bits_fast(24'hC3C3C3, 24);
        exp_frm(6'd1, 2'b00);
        hold(1'b0, 5010);
        check("err_code_after_reset_frame", err_code, 2'b00);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
